fft_spectrum_feeder: RTL and testbench
======================================

// Module: fft_spectrum_feeder
// PURPOSE
//  Responder side of the LCD spectrum user interface. It buffers one FFT magnitude frame per
//  bank in a ping-pong pair of POINTS x 8-bit RAMs, and serves bins to the LCD display engine
//  on request. The display engine supplies data_req, fft_point_done and out_vsync; this block
//  returns fft_point_cnt and fft_data. Banks swap only at frame start, so no frame tears.
// PARAMETERS
//  POINTS  256  bins per displayed frame (2..256); index width fixed at 8
//  DW_IN   16   width of incoming FFT magnitude samples
//  SHIFT   8    right shift applied to s_data before 8-bit saturation
// PORTS
//  clk             in   1      single clock; all LCD-side signals are synchronous to it (CDC external)
//  rst             in   1      asynchronous, active-high reset
//  s_valid         in   1      FFT magnitude sample valid
//  s_data          in   DW_IN  FFT magnitude sample, bin order 0,1,2,...
//  s_last          in   1      last sample of an FFT frame (qualified by s_valid)
//  s_ready         out  1      sample accepted when s_valid & s_ready
//  out_vsync       in   1      frame-start pulse from LCD driver (1 clk)
//  data_req        in   1      display requests fft_data for current fft_point_cnt
//  fft_point_done  in   1      display finished drawing current bin (1 clk pulse)
//  fft_point_cnt   out  8      bin index being served
//  fft_data        out  8      magnitude of bin fft_point_cnt from the read bank
//  frame_swap      out  1      1-clk pulse when the read bank changes
//  short_err       out  1      sticky: frame ended (s_last) with fewer than POINTS samples
//  long_err        out  1      sticky: samples beyond POINTS received before s_last
// BEHAVIOUR
//  Reset values: rd_bank=0, wr_bank=1, wr_addr=0, pending=0, rd_len=0, fft_point_cnt=0,
//    fft_data=0, s_ready=1, frame_swap=0, short_err=0, long_err=0. RAM contents are not cleared.
//  Conversion: mag8 = (s_data>>SHIFT) > 255 ? 255 : (s_data>>SHIFT)[7:0].
//  Write FSM (wr_bank):
//   WR_FILL: s_ready=1. On each accepted sample, write mag8 at wr_addr and increment wr_addr.
//     If s_last is set: wr_len=wr_addr+1 and go to WR_HOLD. short_err is set if wr_len<POINTS.
//     If the sample at wr_addr=POINTS-1 is not last: wr_len=POINTS and go to WR_DROP.
//   WR_DROP: s_ready=1. Accepted samples are discarded and set long_err.
//     The accepted sample with s_last goes to WR_HOLD.
//   WR_HOLD: s_ready=0, pending=1. Wait for swap.
//  Swap: on out_vsync with pending=1 (register value before this edge):
//    - swap rd_bank and wr_bank; rd_len<=wr_len.
//    - pending<=0; wr_addr<=0; write FSM -> WR_FILL.
//    - frame_swap=1 for one clk.
//    out_vsync with pending=0: no swap; the same bank is redisplayed.
//    A bank that completes in the same cycle as out_vsync swaps at the next out_vsync.
//  Read side:
//    - out_vsync: fft_point_cnt<=0, with priority over fft_point_done in the same cycle.
//    - fft_point_done: fft_point_cnt increments, wrapping POINTS-1 -> 0.
//    - data_req: fft_data is updated 1 clk later (sync RAM) to
//      (cnt<rd_len) ? ram[rd_bank][cnt] : 0, using cnt sampled in the data_req cycle.
//      fft_data holds while data_req=0.
//  The read bank is never written. Write and read in the same cycle always hit different banks.
//  Reset mid-frame: the partial write is abandoned. rd_len=0, so fft_data reads 0 until the
//    first swap after a complete frame.
// TESTING
//  1) Reset, then data_req at cnt 0..255 with no frame loaded -> fft_data=0 for every bin.
//     s_ready=1.
//  2) Stream 256 samples with s_data=i<<8 and s_last on i=255, then out_vsync ->
//     frame_swap pulse; data_req/fft_point_done sweep returns fft_data=i (1-clk latency).
//  3) Sample s_data=16'hFFFF -> bin reads 255; s_data=16'h00FF -> bin reads 0.
//  4) Frame of 100 samples with s_last, then swap -> bins 0..99 valid, 100..255 read 0.
//     short_err=1.
//  5) 300 samples, s_last on #299 -> first 256 kept, long_err=1. A second full frame sent
//     before out_vsync sees s_ready=0 until the swap, then fills the other bank.
//  6) out_vsync and fft_point_done in the same clk at cnt=37 -> cnt=0.
//     Frame completing in the vsync clk -> no frame_swap until the next out_vsync.

Source files
------------

// File: rtl/fft_spectrum_feeder.sv
// Ping-pong frame buffer between an FFT magnitude stream and the LCD spectrum display engine.
// Banks swap only on out_vsync after a frame has completed, so a displayed frame never tears.
module fft_spectrum_feeder #(
    parameter int unsigned POINTS = 256,
    parameter int unsigned DW_IN  = 16,
    parameter int unsigned SHIFT  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    input  logic [DW_IN-1:0] s_data,
    input  logic             s_last,
    output logic             s_ready,
    input  logic             out_vsync,
    input  logic             data_req,
    input  logic             fft_point_done,
    output logic [7:0]       fft_point_cnt,
    output logic [7:0]       fft_data,
    output logic             frame_swap,
    output logic             short_err,
    output logic             long_err
);

    localparam logic [8:0] PointsLen = 9'(POINTS);
    localparam logic [7:0] LastIdx   = 8'(POINTS - 1);

    typedef enum logic [1:0] {WrFill, WrDrop, WrHold} wr_state_e;

    wr_state_e        wr_state_q, wr_state_d;
    logic             rd_bank_q, rd_bank_d;
    logic             wr_bank_q, wr_bank_d;
    logic [7:0]       wr_addr_q, wr_addr_d;
    logic [8:0]       wr_len_q, wr_len_d;
    logic [8:0]       rd_len_q, rd_len_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             frame_swap_d, short_err_d, long_err_d;
    logic             pending, accept, swap, ram_we;
    logic [DW_IN-1:0] shifted;
    logic [7:0]       mag8;
    logic [7:0]       mem [2][256];
    logic [7:0]       ram_q;
    logic             hit_q;

    assign shifted = s_data >> SHIFT;
    assign mag8    = (shifted > DW_IN'(255)) ? 8'hFF : shifted[7:0];
    assign pending = (wr_state_q == WrHold);
    assign accept  = s_valid & s_ready;
    // A frame finishing on the vsync edge is not yet pending, so it waits a full display frame.
    assign swap    = out_vsync & pending;

    always_comb begin
        wr_state_d   = wr_state_q;
        rd_bank_d    = rd_bank_q;
        wr_bank_d    = wr_bank_q;
        wr_addr_d    = wr_addr_q;
        wr_len_d     = wr_len_q;
        rd_len_d     = rd_len_q;
        frame_swap_d = 1'b0;
        short_err_d  = short_err;
        long_err_d   = long_err;
        s_ready      = 1'b1;
        ram_we       = 1'b0;
        unique case (wr_state_q)
            WrFill: begin
                if (accept) begin
                    ram_we    = 1'b1;
                    wr_addr_d = wr_addr_q + 8'd1;
                    if (s_last) begin
                        wr_len_d   = {1'b0, wr_addr_q} + 9'd1;
                        wr_state_d = WrHold;
                        if (({1'b0, wr_addr_q} + 9'd1) < PointsLen) short_err_d = 1'b1;
                    end else if (wr_addr_q == LastIdx) begin
                        wr_len_d   = PointsLen;
                        wr_state_d = WrDrop;
                    end
                end
            end
            WrDrop: begin
                if (accept) begin
                    long_err_d = 1'b1;
                    if (s_last) wr_state_d = WrHold;
                end
            end
            WrHold: begin
                s_ready = 1'b0;
                if (swap) begin
                    rd_bank_d    = wr_bank_q;
                    wr_bank_d    = rd_bank_q;
                    rd_len_d     = wr_len_q;
                    wr_addr_d    = 8'd0;
                    wr_state_d   = WrFill;
                    frame_swap_d = 1'b1;
                end
            end
            default: wr_state_d = WrFill;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (out_vsync) begin
            cnt_d = 8'd0;
        end else if (fft_point_done) begin
            cnt_d = (cnt_q == LastIdx) ? 8'd0 : cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state_q <= WrFill;
            rd_bank_q  <= 1'b0;
            wr_bank_q  <= 1'b1;
            wr_addr_q  <= 8'd0;
            wr_len_q   <= 9'd0;
            rd_len_q   <= 9'd0;
            cnt_q      <= 8'd0;
            frame_swap <= 1'b0;
            short_err  <= 1'b0;
            long_err   <= 1'b0;
            hit_q      <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_bank_q  <= rd_bank_d;
            wr_bank_q  <= wr_bank_d;
            wr_addr_q  <= wr_addr_d;
            wr_len_q   <= wr_len_d;
            rd_len_q   <= rd_len_d;
            cnt_q      <= cnt_d;
            frame_swap <= frame_swap_d;
            short_err  <= short_err_d;
            long_err   <= long_err_d;
            if (data_req) hit_q <= ({1'b0, cnt_q} < rd_len_q);
        end
    end

    // Storage has no reset; hit_q masks stale or uninitialised contents.
    always_ff @(posedge clk) begin
        if (ram_we) mem[wr_bank_q][wr_addr_q] <= mag8;
        if (data_req) ram_q <= mem[rd_bank_q][cnt_q];
    end

    assign fft_point_cnt = cnt_q;
    assign fft_data      = hit_q ? ram_q : 8'h00;

endmodule

// File: tb/tb_fft_spectrum_feeder.sv
// Directed bench for fft_spectrum_feeder: frame fill, swap, saturation, short/long frames,
// vsync/done collision and mid-frame reset.
module tb_fft_spectrum_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid, s_last, s_ready;
    logic [15:0] s_data;
    logic        out_vsync, data_req, fft_point_done;
    logic [7:0]  fft_point_cnt, fft_data;
    logic        frame_swap, short_err, long_err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    fft_spectrum_feeder #(.POINTS(256), .DW_IN(16), .SHIFT(8)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready), .out_vsync(out_vsync), .data_req(data_req),
        .fft_point_done(fft_point_done), .fft_point_cnt(fft_point_cnt), .fft_data(fft_data),
        .frame_swap(frame_swap), .short_err(short_err), .long_err(long_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input logic last);
        s_valid = 1'b1; s_data = d; s_last = last;
        step();
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic vsync_pulse();
        out_vsync = 1'b1;
        step();
        out_vsync = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        total_cnt++;
        if ({s_ready, fft_point_cnt, fft_data, frame_swap, short_err, long_err} !== 20'h80000)
            $display("FAIL reset_values: got %h want 80000",
                     {s_ready, fft_point_cnt, fft_data, frame_swap, short_err, long_err});
        else pass_cnt++;
        rst = 1'b0;
        step();
        for (int b = 0; b < 256; b++) begin
            data_req = 1'b1; fft_point_done = 1'b1;
            step();
            total_cnt++;
            if (fft_data !== 8'd0) $display("FAIL empty_bin %0d: got %0d want 0", b, fft_data);
            else pass_cnt++;
        end
        data_req = 1'b0; fft_point_done = 1'b0;
        total_cnt++;
        if (fft_point_cnt !== 8'd0) $display("FAIL cnt_wrap: got %0d want 0", fft_point_cnt);
        else pass_cnt++;
        total_cnt++;
        if (s_ready !== 1'b1) $display("FAIL ready_after_reset: got %b want 1", s_ready);
        else pass_cnt++;
    endtask

    task automatic test_full_frame();
        for (int i = 0; i < 256; i++) send(16'(i << 8), i == 255);
        total_cnt++;
        if ({s_ready, short_err, long_err} !== 3'b000)
            $display("FAIL full_hold: got %b want 000", {s_ready, short_err, long_err});
        else pass_cnt++;
        vsync_pulse();
        total_cnt++;
        if (frame_swap !== 1'b1) $display("FAIL full_swap: got %b want 1", frame_swap);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({frame_swap, s_ready} !== 2'b01)
            $display("FAIL full_swap_end: got %b want 01", {frame_swap, s_ready});
        else pass_cnt++;
        for (int b = 0; b < 256; b++) begin
            data_req = 1'b1; fft_point_done = 1'b1;
            step();
            total_cnt++;
            if (fft_data !== 8'(b)) $display("FAIL full_bin %0d: got %0d want %0d", b, fft_data, b);
            else pass_cnt++;
        end
        data_req = 1'b0;
        repeat (3) step();
        fft_point_done = 1'b0;
        total_cnt++;
        if (fft_data !== 8'd255) $display("FAIL data_hold: got %0d want 255", fft_data);
        else pass_cnt++;
    endtask

    task automatic test_saturation();
        logic [15:0] d;
        logic [7:0]  e;
        for (int i = 0; i < 256; i++) begin
            case (i)
                0: d = 16'hFFFF;
                1: d = 16'h00FF;
                2: d = 16'h1234;
                3: d = 16'h0100;
                default: d = 16'((255 - i) << 8);
            endcase
            send(d, i == 255);
        end
        vsync_pulse();
        total_cnt++;
        if ({frame_swap, short_err, long_err} !== 3'b100)
            $display("FAIL sat_swap: got %b want 100", {frame_swap, short_err, long_err});
        else pass_cnt++;
        for (int b = 0; b < 256; b++) begin
            case (b)
                0: e = 8'd255;
                1: e = 8'd0;
                2: e = 8'h12;
                3: e = 8'd1;
                default: e = 8'(255 - b);
            endcase
            data_req = 1'b1; fft_point_done = 1'b1;
            step();
            total_cnt++;
            if (fft_data !== e) $display("FAIL sat_bin %0d: got %0d want %0d", b, fft_data, e);
            else pass_cnt++;
        end
        data_req = 1'b0; fft_point_done = 1'b0;
    endtask

    task automatic test_short_frame();
        logic [7:0] e;
        for (int i = 0; i < 99; i++) send(16'((i + 7) << 8), 1'b0);
        total_cnt++;
        if (short_err !== 1'b0) $display("FAIL short_early: got %b want 0", short_err);
        else pass_cnt++;
        send(16'((99 + 7) << 8), 1'b1);
        total_cnt++;
        if ({short_err, s_ready} !== 2'b10)
            $display("FAIL short_flag: got %b want 10", {short_err, s_ready});
        else pass_cnt++;
        vsync_pulse();
        for (int b = 0; b < 256; b++) begin
            e = (b < 100) ? 8'(b + 7) : 8'd0;
            data_req = 1'b1; fft_point_done = 1'b1;
            step();
            total_cnt++;
            if (fft_data !== e) $display("FAIL short_bin %0d: got %0d want %0d", b, fft_data, e);
            else pass_cnt++;
        end
        data_req = 1'b0; fft_point_done = 1'b0;
    endtask

    task automatic test_long_frame();
        for (int i = 0; i < 256; i++) send(16'(((i * 3) & 255) << 8), 1'b0);
        total_cnt++;
        if (long_err !== 1'b0) $display("FAIL long_early: got %b want 0", long_err);
        else pass_cnt++;
        for (int i = 256; i < 300; i++) send(16'hAA00, i == 299);
        total_cnt++;
        if ({long_err, s_ready} !== 2'b10)
            $display("FAIL long_flag: got %b want 10", {long_err, s_ready});
        else pass_cnt++;
        // Next frame is offered before vsync and must stall.
        s_valid = 1'b1; s_data = 16'h7700; s_last = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total_cnt++;
            if (s_ready !== 1'b0) $display("FAIL stall_ready %0d: got %b want 0", k, s_ready);
            else pass_cnt++;
            step();
        end
        out_vsync = 1'b1;
        step();
        out_vsync = 1'b0; s_valid = 1'b0;
        total_cnt++;
        if ({frame_swap, s_ready} !== 2'b11)
            $display("FAIL long_swap: got %b want 11", {frame_swap, s_ready});
        else pass_cnt++;
        for (int b = 0; b < 256; b++) begin
            data_req = 1'b1; fft_point_done = 1'b1;
            step();
            total_cnt++;
            if (fft_data !== 8'((b * 3) & 255))
                $display("FAIL long_bin %0d: got %0d want %0d", b, fft_data, (b * 3) & 255);
            else pass_cnt++;
        end
        data_req = 1'b0; fft_point_done = 1'b0;
        for (int i = 0; i < 256; i++) send(16'(((i ^ 'h5A) & 255) << 8), i == 255);
        vsync_pulse();
        for (int b = 0; b < 256; b++) begin
            data_req = 1'b1; fft_point_done = 1'b1;
            step();
            total_cnt++;
            if (fft_data !== 8'((b ^ 'h5A) & 255))
                $display("FAIL second_bin %0d: got %0d want %0d", b, fft_data, (b ^ 'h5A) & 255);
            else pass_cnt++;
        end
        data_req = 1'b0; fft_point_done = 1'b0;
    endtask

    task automatic test_back_to_back();
        vsync_pulse();
        fft_point_done = 1'b1;
        repeat (37) step();
        fft_point_done = 1'b0;
        total_cnt++;
        if (fft_point_cnt !== 8'd37) $display("FAIL cnt_37: got %0d want 37", fft_point_cnt);
        else pass_cnt++;
        out_vsync = 1'b1; fft_point_done = 1'b1;
        step();
        out_vsync = 1'b0; fft_point_done = 1'b0;
        total_cnt++;
        if ({fft_point_cnt, frame_swap} !== 9'd0)
            $display("FAIL collide: got cnt %0d swap %b want cnt 0 swap 0", fft_point_cnt, frame_swap);
        else pass_cnt++;
        for (int i = 0; i < 255; i++) send(16'(((i ^ 'hC3) & 255) << 8), 1'b0);
        out_vsync = 1'b1;
        send(16'(((255 ^ 'hC3) & 255) << 8), 1'b1);
        out_vsync = 1'b0;
        total_cnt++;
        if ({frame_swap, s_ready} !== 2'b00)
            $display("FAIL late_frame: got %b want 00", {frame_swap, s_ready});
        else pass_cnt++;
        for (int b = 0; b < 4; b++) begin
            data_req = 1'b1; fft_point_done = 1'b1;
            step();
            total_cnt++;
            if (fft_data !== 8'((b ^ 'h5A) & 255))
                $display("FAIL redisplay_bin %0d: got %0d want %0d", b, fft_data, (b ^ 'h5A) & 255);
            else pass_cnt++;
        end
        data_req = 1'b0; fft_point_done = 1'b0;
        vsync_pulse();
        total_cnt++;
        if (frame_swap !== 1'b1) $display("FAIL late_swap: got %b want 1", frame_swap);
        else pass_cnt++;
        for (int b = 0; b < 256; b++) begin
            data_req = 1'b1; fft_point_done = 1'b1;
            step();
            total_cnt++;
            if (fft_data !== 8'((b ^ 'hC3) & 255))
                $display("FAIL late_bin %0d: got %0d want %0d", b, fft_data, (b ^ 'hC3) & 255);
            else pass_cnt++;
        end
        data_req = 1'b0; fft_point_done = 1'b0;
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 10; i++) send(16'h4000, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        total_cnt++;
        if ({s_ready, fft_point_cnt, short_err, long_err} !== 11'h400)
            $display("FAIL midreset: got %h want 400", {s_ready, fft_point_cnt, short_err, long_err});
        else pass_cnt++;
        for (int b = 0; b < 4; b++) begin
            data_req = 1'b1; fft_point_done = 1'b1;
            step();
            total_cnt++;
            if (fft_data !== 8'd0) $display("FAIL midreset_bin %0d: got %0d want 0", b, fft_data);
            else pass_cnt++;
        end
        data_req = 1'b0; fft_point_done = 1'b0;
        vsync_pulse();
        total_cnt++;
        if (frame_swap !== 1'b0) $display("FAIL midreset_swap: got %b want 0", frame_swap);
        else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = 16'h0; s_last = 1'b0;
        out_vsync = 1'b0; data_req = 1'b0; fft_point_done = 1'b0;
        test_reset();
        test_full_frame();
        test_saturation();
        test_short_frame();
        test_long_frame();
        test_back_to_back();
        test_reset_midframe();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
